// File: rtl/transfer_register_sequencer_pkg.sv
// Shared definitions for the transfer-register sequencer: micro-op encoding
// and the bit layout of the internal strobe vector.
package transfer_pkg;

   typedef enum logic [3:0] {
      OP_NOP     = 4'd0,
      OP_LD_TL   = 4'd1,
      OP_LD_TH   = 4'd2,
      OP_RD_TL   = 4'd3,
      OP_RD_TH   = 4'd4,
      OP_RD_MODE = 4'd5,
      OP_LD_TX   = 4'd6,
      OP_WR_TX   = 4'd7,
      OP_PTR     = 4'd8,
      OP_LD16    = 4'd9,
      OP_ST16    = 4'd10
   } tx_op_t;

   localparam int unsigned STROBE_W    = 8;
   localparam int unsigned S_A_TL      = 0;
   localparam int unsigned S_L_TL      = 1;
   localparam int unsigned S_A_TH      = 2;
   localparam int unsigned S_L_TH      = 3;
   localparam int unsigned S_L_TX      = 4;
   localparam int unsigned S_A_TX_ADDR = 5;
   localparam int unsigned S_A_TX_XFER = 6;
   localparam int unsigned S_A_TX_MODE = 7;

   // Strobes are active-low on the pins; this is the all-released value.
   localparam logic [STROBE_W-1:0] STROBE_OFF = '1;

endpackage

// File: rtl/transfer_register_sequencer_arbiter.sv
// Address-bus arbiter: grants the memory requester whenever the pipeline is not
// loading a transfer register, and forces it through after STARVE_MAX denials.
module transfer_addr_arbiter #(
   parameter int unsigned STARVE_MAX = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req,
   input  logic in_idle,
   input  logic load_nxt,
   output logic force_mem,
   output logic grant,
   output logic mem_gnt
);
   localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt;

   // Forcing waits for IDLE so the high-byte phase is never interrupted.
   assign force_mem = in_idle && (starve_cnt == CNT_MAX);
   assign grant     = mem_req && (force_mem || !load_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         mem_gnt    <= 1'b0;
      end else begin
         mem_gnt <= grant;
         if (!mem_req || grant)
            starve_cnt <= '0;
         else if (starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/transfer_register_sequencer.sv
// Transfer-register sequencer: converts pipeline micro-ops into registered,
// active-low TL/TH/TX strobes, splitting 16-bit moves into two byte cycles.
module transfer_register_sequencer
   import transfer_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       op_valid,
   input  logic [3:0] op_code,
   output logic       op_ready,
   input  logic       mem_req,
   output logic       mem_gnt,
   output logic       a_tl,
   output logic       a_th,
   output logic       a_tx_mode,
   output logic       a_tx_addr,
   output logic       a_tx_xfer,
   output logic       l_tl,
   output logic       l_th,
   output logic       l_tx,
   output logic       busy,
   output logic       err
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HI   = 1'b1;

   logic [0:0]          state, state_nxt;
   logic                hi_store, hi_store_nxt;
   logic [STROBE_W-1:0] strb_nxt, strb_bus, strb_q;
   logic                accept, illegal, load_nxt, force_mem, grant, in_idle;

   assign in_idle  = (state == ST_IDLE);
   assign op_ready = in_idle && !force_mem;
   assign accept   = op_valid && op_ready;
   assign busy     = (state == ST_HI);

   always_comb begin
      strb_nxt     = '0;
      state_nxt    = ST_IDLE;
      hi_store_nxt = hi_store;
      illegal      = 1'b0;
      if (state == ST_HI) begin
         if (hi_store) strb_nxt[S_A_TH] = 1'b1;
         else          strb_nxt[S_L_TH] = 1'b1;
      end else if (accept) begin
         case (op_code)
            OP_NOP:     ;
            OP_LD_TL:   strb_nxt[S_L_TL]      = 1'b1;
            OP_LD_TH:   strb_nxt[S_L_TH]      = 1'b1;
            OP_RD_TL:   strb_nxt[S_A_TL]      = 1'b1;
            OP_RD_TH:   strb_nxt[S_A_TH]      = 1'b1;
            OP_RD_MODE: strb_nxt[S_A_TX_MODE] = 1'b1;
            OP_LD_TX:   strb_nxt[S_L_TX]      = 1'b1;
            OP_WR_TX:   strb_nxt[S_A_TX_XFER] = 1'b1;
            OP_PTR:     strb_nxt[S_A_TX_ADDR] = 1'b1;
            OP_LD16: begin
               strb_nxt[S_L_TL] = 1'b1;
               state_nxt        = ST_HI;
               hi_store_nxt     = 1'b0;
            end
            OP_ST16: begin
               strb_nxt[S_A_TL] = 1'b1;
               state_nxt        = ST_HI;
               hi_store_nxt     = 1'b1;
            end
            default: illegal = 1'b1;
         endcase
      end
   end

   assign load_nxt = strb_nxt[S_L_TL] || strb_nxt[S_L_TH] || strb_nxt[S_L_TX];

   // A PTR and a memory grant share the one address-drive strobe.
   always_comb begin
      strb_bus              = strb_nxt;
      strb_bus[S_A_TX_ADDR] = strb_nxt[S_A_TX_ADDR] || grant;
   end

   transfer_addr_arbiter #(
      .STARVE_MAX(STARVE_MAX)
   ) u_arbiter (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_req  (mem_req),
      .in_idle  (in_idle),
      .load_nxt (load_nxt),
      .force_mem(force_mem),
      .grant    (grant),
      .mem_gnt  (mem_gnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb_q   <= STROBE_OFF;
         state    <= ST_IDLE;
         hi_store <= 1'b0;
         err      <= 1'b0;
      end else begin
         strb_q   <= ~strb_bus;
         state    <= state_nxt;
         hi_store <= hi_store_nxt;
         if (accept && illegal) err <= 1'b1;
      end
   end

   assign a_tl      = strb_q[S_A_TL];
   assign l_tl      = strb_q[S_L_TL];
   assign a_th      = strb_q[S_A_TH];
   assign l_th      = strb_q[S_L_TH];
   assign l_tx      = strb_q[S_L_TX];
   assign a_tx_addr = strb_q[S_A_TX_ADDR];
   assign a_tx_xfer = strb_q[S_A_TX_XFER];
   assign a_tx_mode = strb_q[S_A_TX_MODE];

endmodule

// File: tb/tb_transfer_register_sequencer.sv
// Scoreboard bench: stimulus pushes the hand-computed output vector for each
// cycle; a negedge monitor pops and compares.
module tb_transfer_register_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       op_valid;
   logic [3:0] op_code;
   logic       op_ready, mem_req, mem_gnt;
   logic       a_tl, a_th, a_tx_mode, a_tx_addr, a_tx_xfer, l_tl, l_th, l_tx, busy, err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [11:0] exp_q[$];
   string       name_q[$];

   // Active strobe masks, bit order {a_tl,l_tl,a_th,l_th,l_tx,a_tx_addr,a_tx_xfer,a_tx_mode}
   localparam logic [7:0] ATL = 8'h80, LTL = 8'h40, ATH = 8'h20, LTH = 8'h10;
   localparam logic [7:0] LTX = 8'h08, ADR = 8'h04, XFR = 8'h02, MOD = 8'h01, NONE = 8'h00;

   always #5 clk = ~clk;

   transfer_register_sequencer #(.STARVE_MAX(2)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
      .op_ready(op_ready), .mem_req(mem_req), .mem_gnt(mem_gnt),
      .a_tl(a_tl), .a_th(a_th), .a_tx_mode(a_tx_mode), .a_tx_addr(a_tx_addr),
      .a_tx_xfer(a_tx_xfer), .l_tl(l_tl), .l_th(l_th), .l_tx(l_tx),
      .busy(busy), .err(err)
   );

   function automatic logic [11:0] mk(input logic rdy, input logic gnt, input logic bsy,
                                      input logic er, input logic [7:0] act);
      return {rdy, gnt, bsy, er, ~act};
   endfunction

   task automatic step(input logic v, input logic [3:0] c, input logic r,
                       input logic [11:0] e, input string nm);
      @(posedge clk);
      #1;
      op_valid = v;
      op_code  = c;
      mem_req  = r;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [11:0] got, e;
         string nm;
         got = {op_ready, mem_gnt, busy, err, a_tl, l_tl, a_th, l_th, l_tx,
                a_tx_addr, a_tx_xfer, a_tx_mode};
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", nm, got, e);
         end
      end
   end

   initial begin
      rst_n = 1'b0; op_valid = 1'b0; op_code = 4'd0; mem_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // single-cycle ops, one main-bus enable per cycle
      step(0, 4'd0, 0, mk(1,0,0,0,NONE), "reset_idle");
      step(1, 4'd1, 0, mk(1,0,0,0,NONE), "nop_no_strobe");
      step(1, 4'd2, 0, mk(1,0,0,0,LTL),  "ld_tl");
      step(1, 4'd3, 0, mk(1,0,0,0,LTH),  "ld_th");
      step(1, 4'd4, 0, mk(1,0,0,0,ATL),  "rd_tl");
      step(1, 4'd5, 0, mk(1,0,0,0,ATH),  "rd_th");
      step(1, 4'd6, 0, mk(1,0,0,0,MOD),  "rd_mode");
      step(1, 4'd7, 0, mk(1,0,0,0,LTX),  "ld_tx");
      step(1, 4'd8, 0, mk(1,0,0,0,XFR),  "wr_tx");
      step(0, 4'd0, 0, mk(1,0,0,0,ADR),  "ptr");
      // LD16 back to back; second held through the HI cycle
      step(1, 4'd9, 0, mk(1,0,0,0,NONE), "pre_ld16");
      step(1, 4'd9, 0, mk(0,0,1,0,LTL),  "ld16_lo");
      step(1, 4'd9, 0, mk(1,0,0,0,LTH),  "ld16_hi_accept2");
      step(0, 4'd0, 0, mk(0,0,1,0,LTL),  "ld16b_lo");
      step(0, 4'd0, 0, mk(1,0,0,0,LTH),  "ld16b_hi");
      step(1, 4'd10,0, mk(1,0,0,0,NONE), "pre_st16");
      step(0, 4'd0, 0, mk(0,0,1,0,ATL),  "st16_lo");
      step(0, 4'd0, 0, mk(1,0,0,0,ATH),  "st16_hi");
      // starvation under a continuous LD_TX stream
      step(1, 4'd6, 1, mk(1,0,0,0,NONE), "starve_start");
      step(1, 4'd6, 1, mk(1,0,0,0,LTX),  "deny1");
      step(1, 4'd6, 1, mk(0,0,0,0,LTX),  "deny2_force");
      step(1, 4'd6, 0, mk(1,1,0,0,ADR),  "forced_grant");
      step(1, 4'd7, 1, mk(1,0,0,0,LTX),  "ld_tx_after_grant");
      step(1, 4'd8, 1, mk(1,1,0,0,ADR|XFR), "grant_with_wr_tx");
      step(0, 4'd0, 0, mk(1,1,0,0,ADR),  "grant_with_ptr");
      // counter restarted from zero after the forced grant
      step(1, 4'd6, 1, mk(1,0,0,0,NONE), "restart");
      step(1, 4'd6, 1, mk(1,0,0,0,LTX),  "cnt_was_zero");
      step(0, 4'd0, 1, mk(0,0,0,0,LTX),  "force_again");
      step(0, 4'd0, 0, mk(1,1,0,0,ADR),  "grant_again");
      // saturation during HI: force waits for IDLE
      step(1, 4'd6, 1, mk(1,0,0,0,NONE), "sat_start");
      step(1, 4'd9, 1, mk(1,0,0,0,LTX),  "sat_deny1");
      step(0, 4'd0, 1, mk(0,0,1,0,LTL),  "sat_hi_no_force");
      step(0, 4'd0, 1, mk(0,0,0,0,LTH),  "sat_force_idle");
      step(0, 4'd0, 0, mk(1,1,0,0,ADR),  "sat_grant");
      // illegal opcode, sticky err
      step(1, 4'd13,0, mk(1,0,0,0,NONE), "pre_illegal");
      step(1, 4'd3, 0, mk(1,0,0,1,NONE), "illegal_no_strobe");
      step(0, 4'd0, 0, mk(1,0,0,1,ATL),  "err_sticky_rd");
      step(1, 4'd9, 0, mk(1,0,0,1,NONE), "err_sticky");
      // async reset during LD16 HI phase
      step(0, 4'd0, 0, mk(1,0,0,0,NONE), "async_reset");
      #1 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      step(0, 4'd0, 0, mk(1,0,0,0,NONE), "no_hi_after_reset");
      step(1, 4'd1, 0, mk(1,0,0,0,NONE), "post_reset_idle");
      step(0, 4'd0, 0, mk(1,0,0,0,LTL),  "post_reset_latency");
      step(0, 4'd0, 0, mk(1,0,0,0,NONE), "final_idle");
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/transfer_register_sequencer.md
Name: transfer_register_sequencer

Overview:
- Control-side sequencer for the 16-bit transfer register (TL/TH byte halves plus TX).
- Turns pipeline transfer micro-ops into registered, active-low assert/load strobes (a_tl, l_tl, a_th, l_th, l_tx, a_tx_addr, a_tx_xfer, a_tx_mode).
- Splits 16-bit main-bus moves into two byte cycles.
- Arbitrates the address-bus drive between the pipeline and a memory-address requester, with bounded starvation.

Parameters:
- STARVE_MAX, 2, consecutive mem_req denials before the memory requester is forced through.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  pipeline presents an op.
- op_code  input  4  micro-op (tx_op_t).
- op_ready  output  1  sequencer accepts op this cycle.
- mem_req  input  1  memory unit wants TX on Addr; held until granted.
- mem_gnt  output  1  one-cycle grant, coincident with a_tx_addr low.
- a_tl, a_th, a_tx_mode, a_tx_addr, a_tx_xfer  output  1 each  active-low bus drive enables.
- l_tl, l_th, l_tx  output  1 each  active-low load strobes.
- busy  output  1  second phase of a 16-bit op in progress.
- err  output  1  sticky; illegal opcode seen.

Behaviour:
- All strobe outputs are registered; no combinational path from inputs to strobes.
- Reset: all a_*/l_* = 1; mem_gnt=0, busy=0, err=0; FSM=IDLE; starvation counter=0.
- op_ready is combinational from state only: 1 in IDLE unless force_mem is active; 0 in HI.
- Accept = op_valid & op_ready at posedge N. Strobes are active during cycle N+1 (latency 1).
- Ops:
  - NOP: no strobes.
  - LD_TL: l_tl.
  - LD_TH: l_th.
  - RD_TL: a_tl.
  - RD_TH: a_th.
  - RD_MODE: a_tx_mode.
  - LD_TX: l_tx.
  - WR_TX: a_tx_xfer.
  - PTR: a_tx_addr.
  - LD16: cycle N+1 l_tl, cycle N+2 l_th.
  - ST16: cycle N+1 a_tl, cycle N+2 a_th.
- FSM:
  - IDLE→HI on accepting LD16 or ST16.
  - HI→IDLE unconditionally after one cycle.
  - busy=1 while in HI.
  - In HI the high-byte strobe is issued regardless of op_valid.
- Main-bus exclusivity: at most one of a_tl, a_th, a_tx_mode is low in any cycle. RD_*, ST16 and RD_MODE are serialised by construction.
- Arbitration, evaluated at each posedge:
  - Memory is granted (mem_gnt=1, a_tx_addr=0 next cycle) when mem_req=1 and the pipeline strobe issued that cycle is none of l_tl, l_th, l_tx.
  - Otherwise the request is denied and the starvation counter increments.
  - Grant with a concurrent RD_*/WR_TX/PTR is legal. A PTR plus a memory grant yields a single a_tx_addr=0.
  - When counter==STARVE_MAX: force_mem=1, op_ready=0 for one cycle, memory is granted, counter clears.
  - Counter clears on any grant and when mem_req=0.
  - force_mem is never asserted while in HI. It waits until IDLE; the counter saturates at STARVE_MAX.
- Illegal opcode (codes 11–15) accepted: acts as NOP; err set, cleared only by reset.
- Async reset mid-LD16/ST16: strobes release immediately. The high-byte phase is not issued after reset release.

Decomposition:
- Shared package transfer_pkg holds:
  - tx_op_t 4-bit enum: NOP=0, LD_TL=1, LD_TH=2, RD_TL=3, RD_TH=4, RD_MODE=5, LD_TX=6, WR_TX=7, PTR=8, LD16=9, ST16=10.
  - Strobe-bit index constants.
  - Active-low inactive value constant.
- One sub-module is natural: transfer_addr_arbiter, holding the starvation counter, force_mem and mem_gnt logic.

Test Plan:
- Reset: assert rst_n=0 mid-run → all a_*/l_* =1, mem_gnt=0, busy=0, err=0 asynchronously. First op after release has 1-cycle latency.
- LD16 accepted at edge 0 → l_tl=0 in cycle 1 and l_th=0 in cycle 2; op_ready=0 and busy=1 in cycle 1; a second LD16 presented in cycle 1 is accepted at the start of cycle 2.
- Back-to-back RD_TL, RD_TH, RD_MODE → exactly one main-bus enable low per cycle, in order, no overlap.
- mem_req held with continuous LD_TX stream, STARVE_MAX=2 → two denials, then op_ready=0 one cycle, mem_gnt=1 and a_tx_addr=0 on cycle 3; counter returns to 0.
- mem_req with concurrent WR_TX → same-cycle mem_gnt=1, a_tx_addr=0 and a_tx_xfer=0.
- op_code=13 → no strobes, err=1 and sticky across subsequent valid ops until reset; assert rst_n=0 during LD16 HI phase → l_th never pulses.
